// File: rtl/mips_int_ctrl.sv
// Interrupt controller for the pipelined MIPS core: synchronise, latch, prioritise, take and return.
// Build option INT_LEVEL_EN: pending follows the synchronised line level (no latch, no edge detect).
module mips_int_ctrl #(
  parameter int          NUM_IRQ       = 4,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] HANDLER_BASE  = 32'h0000_0100,
  parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010,
  localparam int         CW            = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask,
  output logic               int_req,
  input  logic               int_ack,
  input  logic [31:0]        epc_in,
  input  logic               eret,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        epc_out,
  output logic [CW-1:0]      cause_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic               ie;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_lvl;
  logic [NUM_IRQ-1:0] eligible;
  logic [CW-1:0]      winner;
  logic               take;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign take     = (state == REQ) && int_ack;

  // NOTE: the synchroniser array is reset element by element so no stage can
  // present X (and a phantom edge) to the pending logic after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef INT_LEVEL_EN
  assign pending = sync_lvl;
`else
  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_clr;

  assign rise    = sync_lvl & ~hist_q;
  assign ack_clr = take ? (NUM_IRQ'(1) << cause_id) : '0;

  // A fresh edge in the same cycle as the ack clear keeps the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      pending <= '0;
    end else begin
      hist_q  <= sync_lvl;
      pending <= (pending & ~ack_clr) | rise;
    end
  end
`endif

  assign eligible = pending & mask;

  // NOTE: winner gets a default before the loop; without it this block would
  // infer a latch for the cycles where nothing is eligible.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) winner = CW'(i);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; redirect's default is overridden later in
  // the same block, and the last scheduled update wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ie          <= 1'b1;
      mask        <= '1;
      int_req     <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      epc_out     <= '0;
      cause_id    <= '0;
      in_service  <= 1'b0;
    end else begin
      redirect <= 1'b0;
      if (mask_we) mask <= mask_wdata;

      unique case (state)
        IDLE: begin
          if (ie && (|eligible)) begin
            cause_id <= winner;
            int_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          // cause_id is frozen here; mask or pending changes do not re-arbitrate.
          if (take) begin
            epc_out     <= epc_in;
            ie          <= 1'b0;
            int_req     <= 1'b0;
            in_service  <= 1'b1;
            redirect    <= 1'b1;
            redirect_pc <= HANDLER_BASE + VECTOR_STRIDE * 32'(cause_id);
            state       <= SERVICE;
          end
        end
        SERVICE: begin
          if (eret) begin
            redirect    <= 1'b1;
            redirect_pc <= epc_out;
            ie          <= 1'b1;
            in_service  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Bench for mips_int_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_mips_int_ctrl;
  localparam int N = 4;
  localparam int S = 2;
`ifdef INT_LEVEL_EN
  localparam bit LEVEL = 1'b1;
`else
  localparam bit LEVEL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_wdata = '0;
  logic          int_ack = 1'b0;
  logic [31:0]   epc_in = '0;
  logic          eret = 1'b0;
  logic [N-1:0]  mask, pending;
  logic          int_req, redirect, in_service;
  logic [31:0]   redirect_pc, epc_out;
  logic [1:0]    cause_id;

  always #5 clk = ~clk;

  mips_int_ctrl dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask(mask), .int_req(int_req), .int_ack(int_ack), .epc_in(epc_in), .eret(eret),
    .redirect(redirect), .redirect_pc(redirect_pc), .epc_out(epc_out),
    .cause_id(cause_id), .in_service(in_service), .pending(pending)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_REQ, M_SVC} mstate_t;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  mstate_t      ms, ms_n;
  logic [N-1:0] hm [0:S];          // raw irq_in samples, [0] = most recent edge
  logic [N-1:0] mp, mp_n, mmask, mmask_n;
  logic         mie, mie_n, mreq, mreq_n, mredir, mredir_n, msvc, msvc_n;
  logic [31:0]  mrpc, mrpc_n, mepc, mepc_n;
  int           mcause, mcause_n;

  always_comb begin
    logic [N-1:0] clr;
    logic [N-1:0] rise;
    int w;
    ms_n = ms; mp_n = mp; mmask_n = mmask; mie_n = mie; mreq_n = mreq;
    mredir_n = 1'b0; msvc_n = msvc; mrpc_n = mrpc; mepc_n = mepc; mcause_n = mcause;
    clr  = '0;
    rise = hm[S-1] & ~hm[S];
    w    = lowest(mp & mmask);
    case (ms)
      M_IDLE: if (mie && w >= 0) begin
        mcause_n = w; mreq_n = 1'b1; ms_n = M_REQ;
      end
      M_REQ: if (int_ack) begin
        mepc_n = epc_in; mie_n = 1'b0; mreq_n = 1'b0; msvc_n = 1'b1; mredir_n = 1'b1;
        mrpc_n = 32'h100 + 32'(mcause) * 32'h10;
        clr[mcause] = 1'b1;
        ms_n = M_SVC;
      end
      default: if (eret) begin
        mredir_n = 1'b1; mrpc_n = mepc; mie_n = 1'b1; msvc_n = 1'b0; ms_n = M_IDLE;
      end
    endcase
    if (mask_we) mmask_n = mask_wdata;
    if (LEVEL) mp_n = hm[S-2];
    else       mp_n = (mp & ~clr) | rise;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms <= M_IDLE; mp <= '0; mmask <= '1; mie <= 1'b1; mreq <= 1'b0; mredir <= 1'b0;
      msvc <= 1'b0; mrpc <= '0; mepc <= '0; mcause <= 0;
      for (int j = 0; j <= S; j++) hm[j] <= '0;
    end else begin
      ms <= ms_n; mp <= mp_n; mmask <= mmask_n; mie <= mie_n; mreq <= mreq_n;
      mredir <= mredir_n; msvc <= msvc_n; mrpc <= mrpc_n; mepc <= mepc_n; mcause <= mcause_n;
      hm[0] <= irq_in;
      for (int j = 1; j <= S; j++) hm[j] <= hm[j-1];
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("m_int_req",     int_req,     mreq);
    check("m_redirect",    redirect,    mredir);
    check("m_redirect_pc", redirect_pc, mrpc);
    check("m_epc_out",     epc_out,     mepc);
    check("m_cause_id",    cause_id,    mcause);
    check("m_in_service",  in_service,  msvc);
    check("m_mask",        mask,        mmask);
    check("m_pending",     pending,     mp);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (int_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, int_req, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_int_req"}, int_req, 0);
    check({tag, "_redirect"}, redirect, 0);
    check({tag, "_redirect_pc"}, redirect_pc, 0);
    check({tag, "_epc_out"}, epc_out, 0);
    check({tag, "_cause_id"}, cause_id, 0);
    check({tag, "_in_service"}, in_service, 0);
    check({tag, "_pending"}, pending, 0);
    check({tag, "_mask"}, mask, 4'hf);
  endtask

  initial begin
    step(3);
    rst = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_int_req", int_req, 0);
      check("idle_redirect", redirect, 0);
      check("idle_mask", mask, 4'hf);
      check("idle_in_service", in_service, 0);
    end

    // Line 0 pulse, take and return.
    irq_in[0] = 1'b1;
    step(3);
    check("l0_req_early", int_req, LEVEL);
    check("l0_pending", pending[0], 1);
    irq_in[0] = 1'b0;
    step(1);
    check("l0_req_lat", int_req, 1);
    check("l0_cause", cause_id, 0);
    step(2);
    int_ack = 1'b1; epc_in = 32'h0000_0040;
    step(1);
    int_ack = 1'b0;
    check("l0_redirect", redirect, 1);
    check("l0_vector", redirect_pc, 32'h0000_0100);
    check("l0_epc", epc_out, 32'h0000_0040);
    check("l0_pending_clr", pending[0], 0);
    check("l0_in_service", in_service, 1);
    check("l0_req_drop", int_req, 0);
    step(1);
    check("l0_redirect_1cyc", redirect, 0);
    step(2);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("eret_redirect", redirect, 1);
    check("eret_pc", redirect_pc, 32'h0000_0040);
    check("eret_in_service", in_service, 0);
    check("eret_int_req", int_req, 0);
    step(1);
    check("eret_redirect_1cyc", redirect, 0);

    // Lines 2 and 1 together: line 1 first, then line 2.
    irq_in = 4'b0110;
    wait_req("pri_wait1");
    check("pri_cause1", cause_id, 1);
    int_ack = 1'b1; epc_in = 32'h0000_0200; irq_in[1] = 1'b0;
    step(1);
    int_ack = 1'b0;
    check("pri_vec1", redirect_pc, 32'h0000_0110);
    step(4);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("pri_ret1", redirect_pc, 32'h0000_0200);
    wait_req("pri_wait2");
    check("pri_cause2", cause_id, 2);
    int_ack = 1'b1; epc_in = 32'h0000_0300; irq_in[2] = 1'b0;
    step(1);
    int_ack = 1'b0;
    check("pri_vec2", redirect_pc, 32'h0000_0120);
    step(4);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("pri_ret2", redirect_pc, 32'h0000_0300);
    step(6);
    check("pri_quiet", int_req, 0);

    // Masked line stays pending until unmasked.
    mask_we = 1'b1; mask_wdata = 4'b1110;
    step(1);
    mask_we = 1'b0;
    check("mask_wr", mask, 4'b1110);
    irq_in[0] = 1'b1;
    step(4);
    check("mask_pending", pending[0], 1);
    check("mask_blocked", int_req, 0);
    step(2);
    check("mask_blocked2", int_req, 0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step(1);
    mask_we = 1'b0;
    check("unmask_wr", mask, 4'hf);
    step(1);
    check("unmask_req", int_req, 1);
    int_ack = 1'b1; epc_in = 32'h0000_0080; irq_in[0] = 1'b0;
    step(1);
    int_ack = 1'b0;
    check("unmask_vec", redirect_pc, 32'h0000_0100);
    step(4);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    step(6);

    // Reset while in REQ.
    irq_in[3] = 1'b1;
    step(3);
    irq_in[3] = 1'b0;
    wait_req("rst_req_wait");
    check("rst_req_cause", cause_id, 3);
    rst = 1'b0;
    #1;
    check_reset_outs("rst_req");
    step(2);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("rst_req_noredir", redirect, 0);
      check("rst_req_noreq", int_req, 0);
    end

    // Reset while in SERVICE.
    irq_in[1] = 1'b1;
    step(3);
    irq_in[1] = 1'b0;
    wait_req("rst_svc_wait");
    int_ack = 1'b1; epc_in = 32'h0000_0055;
    step(1);
    int_ack = 1'b0;
    check("rst_svc_in", in_service, 1);
    step(1);
    rst = 1'b0;
    #1;
    check_reset_outs("rst_svc");
    step(2);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("rst_svc_noredir", redirect, 0);
      check("rst_svc_idle", in_service, 0);
    end

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
      mask_we    = ($urandom_range(19) == 0);
      mask_wdata = N'($urandom) | N'($urandom);
      int_ack    = ($urandom_range(3) == 0);
      eret       = ($urandom_range(5) == 0);
      epc_in     = $urandom;
      if (i == 1500) rst = 1'b0;
      if (i == 1503) rst = 1'b1;
      step(1);
    end
    irq_in = '0; mask_we = 1'b0; int_ack = 1'b0; eret = 1'b0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_int_ctrl.md
Name: mips_int_ctrl

Overview:
- Interrupt controller and sequencer for the pipelined MIPS core.
- Synchronises the external interrupt lines (bit 0 is the core's `interrupter` input), latches and masks pending requests, and picks the highest-priority one.
- Handshakes with the pipeline to take the interrupt at an instruction boundary, saves the EPC and redirects the PC to a per-line vector.
- Later returns control to the EPC when the pipeline decodes ERET.

Parameters:
- NUM_IRQ, 4, number of interrupt lines; bit 0 has the highest priority.
- SYNC_STAGES, 2, flip-flop synchroniser depth per line (minimum 2).
- HANDLER_BASE, 32'h0000_0100, vector address of line 0.
- VECTOR_STRIDE, 32'h0000_0010, address step between consecutive line vectors.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw asynchronous interrupt lines.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  NUM_IRQ  new mask value; 1 = enabled.
- mask  out  NUM_IRQ  current mask register.
- int_req  out  1  interrupt request to the pipeline.
- int_ack  in  1  pipeline has flushed at a boundary and accepts the request.
- epc_in  in  32  PC of the first unexecuted instruction, valid while int_ack=1.
- eret  in  1  one-cycle pulse when ERET is decoded.
- redirect  out  1  one-cycle pulse: load redirect_pc into the PC.
- redirect_pc  out  32  target PC for redirect.
- epc_out  out  32  saved EPC.
- cause_id  out  log2(NUM_IRQ) (min 1)  line currently requested or in service.
- in_service  out  1  handler is running.
- pending  out  NUM_IRQ  pending latch.

Behaviour:
- Reset (rst=0, asynchronous) clears these to 0:
  - synchronisers, edge-detect history, pending, state, int_req, redirect, redirect_pc, epc_out, cause_id, in_service.
  - Reset forces mask to all 1s and the global enable ie to 1.
  - Reset mid-request or mid-handler abandons the operation with no redirect.
- Input path:
  - Each line passes through SYNC_STAGES flip-flops, then a history flip-flop.
  - A synchronised rising edge sets pending[i].
  - Latency with SYNC_STAGES=2: irq_in rises before edge k → pending[i] set at edge k+2 → int_req high at edge k+3.
  - A line held high produces only one pending set; it must fall and rise again to set pending again.
- Selection: eligible = pending & mask. The winner is the lowest-index set bit.
- State machine:
  - IDLE: if ie=1 and eligible≠0, latch the winner into cause_id, set int_req=1, go to REQ. An eret pulse in IDLE is ignored.
  - REQ:
    - int_req stays high and cause_id stays frozen until int_ack, even if the mask or pending changes.
    - On int_ack:
      - epc_out←epc_in.
      - ie←0, int_req←0, in_service←1.
      - pending[cause_id]←0.
      - redirect pulses 1 for exactly one cycle with redirect_pc = HANDLER_BASE + cause_id*VECTOR_STRIDE (32-bit, modulo 2^32).
      - Go to SERVICE.
    - eret is ignored in REQ.
  - SERVICE:
    - No nesting; new edges only set pending.
    - On eret: redirect pulses with redirect_pc=epc_out, ie←1, in_service←0, go to IDLE.
    - Next request no earlier than the cycle after the return.
    - int_ack outside REQ is ignored.
- Simultaneous events:
  - A new edge on line i in the same cycle its pending bit is cleared by the ack: the set wins and pending[i] stays 1.
  - mask_we in any state takes effect at the next edge. It affects selection only in IDLE.

Optional Feature:
- Macro: INT_LEVEL_EN.
- Defined:
  - pending[i] is the synchronised level itself; there is no latch and no edge detect.
  - The ack does not clear pending, so the source must drop the line before eret, otherwise the request repeats immediately.
  - pending follows the input with SYNC_STAGES cycles of latency.
- Undefined: edge-latched behaviour as described above.

Test Plan:
- Reset release, irq_in=0 → int_req=0, redirect=0, mask=4'b1111, in_service=0 for 20 cycles.
- Pulse irq_in[0] for 3 cycles; int_ack asserted 2 cycles after int_req with epc_in=32'h0000_0040 → int_req high at edge 3 after the rise; one-cycle redirect with redirect_pc=32'h0000_0100; epc_out=32'h0000_0040; pending[0]=0; in_service=1.
- After the previous test, pulse eret → one-cycle redirect with redirect_pc=32'h0000_0040; in_service=0; int_req=0.
- Raise irq_in[2] and irq_in[1] in the same cycle, then ack each request and eret each handler → first vector 32'h0000_0110 (cause_id=1), then 32'h0000_0120 (cause_id=2) after eret.
- Write mask=4'b1110, pulse irq_in[0] → pending[0]=1 and int_req stays 0. Then write mask=4'b1111 → int_req rises the next cycle.
- Assert rst low while in REQ or in SERVICE → all outputs 0 immediately; mask=4'b1111; no redirect after rst returns high.
